// File: rtl/e_xalu.sv
// e_xalu: E-stage ALU plus multi-cycle multiply/divide engine owning HI/LO.
// Ports: A/B/ALUop/ovf/load/store -> ALUres + flags; MDop/start/cancel -> HI/LO/busy/md_stall.
module e_xalu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  input  logic             ovf,
  input  logic             load,
  input  logic             store,
  input  logic [2:0]       MDop,
  input  logic             start,
  input  logic             cancel,
  output logic [WIDTH-1:0] ALUres,
  output logic             ALU_ov,
  output logic             ALU_AdEL,
  output logic             ALU_AdES,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             md_stall
);

  localparam int W    = WIDTH;
  localparam int SW   = $clog2(W);
  localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ?
                        MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } st_e;

  // ---------------- ALU ----------------
  logic [W:0]    sum;
  logic [W:0]    dif;
  logic [SW-1:0] sh;
  logic [W-1:0]  res;
  logic          o;

  assign sum = {A[W-1], A} + {B[W-1], B};
  assign dif = {A[W-1], A} - {B[W-1], B};
  assign sh  = A[SW-1:0];

  always_comb begin
    res = '0;
    o   = 1'b0;
    case (ALUop)
      4'd0: begin
        res = sum[W-1:0];
        o   = sum[W] ^ sum[W-1];
      end
      4'd1: begin
        res = dif[W-1:0];
        o   = dif[W] ^ dif[W-1];
      end
      4'd2:  res = A | B;
      4'd3:  res = A & B;
      4'd4:  res = {B[W/2-1:0], {(W/2){1'b0}}};
      4'd5:  res = {{(W-1){1'b0}},
                    $signed(A) < $signed(B)};
      4'd6:  res = {{(W-1){1'b0}}, A < B};
      4'd7:  res = A ^ B;
      4'd8:  res = ~(A | B);
      4'd9:  res = B << sh;
      4'd10: res = B >> sh;
      4'd11: res = $signed(B) >>> sh;
      default: res = '0;
    endcase
  end

  assign ALUres   = res;
  assign ALU_ov   = ovf & o;
  assign ALU_AdEL = load & o;
  assign ALU_AdES = store & o;

  // ---------------- MD datapath ----------------
  logic           acc;
  logic           is_md;
  logic           smul;
  logic           sdiv;
  logic [2*W-1:0] ea;
  logic [2*W-1:0] eb;
  logic [2*W-1:0] prod;
  logic           neg_a;
  logic           neg_b;
  logic [W-1:0]   ua;
  logic [W-1:0]   ub;
  logic [W-1:0]   ubd;
  logic [W-1:0]   uq;
  logic [W-1:0]   ur;
  logic [W-1:0]   dq;
  logic [W-1:0]   dr;
  logic           dz;

  assign acc   = start & ~cancel;
  assign is_md = (MDop >= 3'd1) && (MDop <= 3'd4);
  assign smul  = (MDop == 3'd1);
  assign sdiv  = (MDop == 3'd3);

  assign ea   = smul ? {{W{A[W-1]}}, A} : {{W{1'b0}}, A};
  assign eb   = smul ? {{W{B[W-1]}}, B} : {{W{1'b0}}, B};
  assign prod = ea * eb;

  // Sign-magnitude divide. The most-negative / -1 case falls out
  // naturally: |A| wraps to A, quotient negates back to A, rem 0.
  assign neg_a = sdiv & A[W-1];
  assign neg_b = sdiv & B[W-1];
  assign ua    = neg_a ? -A : A;
  assign ub    = neg_b ? -B : B;
  assign dz    = (B == '0);
  assign ubd   = dz ? {{(W-1){1'b0}}, 1'b1} : ub;
  assign uq    = ua / ubd;
  assign ur    = ua % ubd;
  assign dq    = dz ? '1 : ((neg_a ^ neg_b) ? -uq : uq);
  assign dr    = dz ? A  : (neg_a ? -ur : ur);

  // ---------------- MD FSM ----------------
  st_e           state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  ph_q;
  logic [W-1:0]  pl_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic          busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            case (MDop)
              3'd1, 3'd2: begin
                ph_q    <= prod[2*W-1:W];
                pl_q    <= prod[W-1:0];
                cnt_q   <= MUL_N;
                state_q <= MUL;
                busy_q  <= 1'b1;
              end
              3'd3, 3'd4: begin
                ph_q    <= dr;
                pl_q    <= dq;
                cnt_q   <= DIV_N;
                state_q <= DIV;
                busy_q  <= 1'b1;
              end
              3'd5: hi_q <= A;
              3'd6: lo_q <= A;
              default: ;
            endcase
          end
        end
        default: begin
          if (cnt_q == ONE) begin
            hi_q    <= ph_q;
            lo_q    <= pl_q;
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
      endcase
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = busy_q;
  assign md_stall = busy_q | (acc & is_md);

endmodule

// File: tb/tb_e_xalu.sv
// tb_e_xalu: directed + randomized checks of e_xalu against a
// behavioural model (WIDTH=32 instance plus a WIDTH=16 instance).
module tb_e_xalu;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  aluop = '0;
  logic        fovf = 1'b0;
  logic        fld = 1'b0;
  logic        fst = 1'b0;
  logic [2:0]  mdop = '0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] res;
  logic        ov;
  logic        adel;
  logic        ades;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  logic [15:0] h_a = '0;
  logic [15:0] h_b = '0;
  logic [3:0]  h_aluop = '0;
  logic [2:0]  h_mdop = '0;
  logic        h_start = 1'b0;
  logic [15:0] h_res;
  logic        h_ov;
  logic        h_adel;
  logic        h_ades;
  logic [15:0] h_hi;
  logic [15:0] h_lo;
  logic        h_busy;
  logic        h_stall;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  e_xalu u32 (
    .clk(clk), .reset(reset), .A(a), .B(b),
    .ALUop(aluop), .ovf(fovf), .load(fld), .store(fst),
    .MDop(mdop), .start(start), .cancel(cancel),
    .ALUres(res), .ALU_ov(ov), .ALU_AdEL(adel),
    .ALU_AdES(ades), .HI(hi), .LO(lo),
    .busy(busy), .md_stall(stall)
  );

  e_xalu #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .A(h_a), .B(h_b),
    .ALUop(h_aluop), .ovf(1'b1), .load(1'b0),
    .store(1'b0), .MDop(h_mdop), .start(h_start),
    .cancel(1'b0), .ALUres(h_res), .ALU_ov(h_ov),
    .ALU_AdEL(h_adel), .ALU_AdES(h_ades),
    .HI(h_hi), .LO(h_lo), .busy(h_busy),
    .md_stall(h_stall)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_model(input logic [3:0] op,
                           input logic [31:0] x,
                           input logic [31:0] y,
                           output logic [31:0] r,
                           output logic o);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    o = 1'b0;
    case (op)
      4'd0: begin
        s = sx + sy; r = s[31:0];
        o = (s > MAXS) || (s < MINS);
      end
      4'd1: begin
        s = sx - sy; r = s[31:0];
        o = (s > MAXS) || (s < MINS);
      end
      4'd2:  r = x | y;
      4'd3:  r = x & y;
      4'd4:  r = {y[15:0], 16'h0000};
      4'd5:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6:  r = (x < y) ? 32'd1 : 32'd0;
      4'd7:  r = x ^ y;
      4'd8:  r = ~(x | y);
      4'd9:  r = y << x[4:0];
      4'd10: r = y >> x[4:0];
      4'd11: r = $signed(y) >>> x[4:0];
      default: r = '0;
    endcase
  endtask

  task automatic alu_chk(input logic [3:0] op,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [2:0] fl);
    logic [31:0] r;
    logic o;
    aluop = op; a = x; b = y;
    {fovf, fld, fst} = fl;
    #1;
    alu_model(op, x, y, r, o);
    chk("alu_res", {32'd0, res}, {32'd0, r});
    chk("alu_flags", {61'd0, ov, adel, ades},
        {61'd0, fl & {3{o}}});
  endtask

  task automatic md_model(input logic [2:0] op,
                          input logic [31:0] x,
                          input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd1: begin
        p = sx * sy;
        mhi = p[63:32]; mlo = p[31:0];
      end
      3'd2: begin
        up = {32'd0, x} * {32'd0, y};
        mhi = up[63:32]; mlo = up[31:0];
      end
      3'd3: begin
        if (y == 0) begin
          mlo = '1; mhi = x;
        end else if (x == 32'h8000_0000 &&
                     y == 32'hFFFF_FFFF) begin
          mlo = x; mhi = '0;
        end else begin
          p = sx / sy; mlo = p[31:0];
          p = sx % sy; mhi = p[31:0];
        end
      end
      3'd4: begin
        if (y == 0) begin
          mlo = '1; mhi = x;
        end else begin
          mlo = x / y; mhi = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Caller is at posedge+1 with busy low.
  task automatic md_run(input logic [2:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input bit inject);
    logic [31:0] ohi, olo;
    int n, lat;
    ohi = mhi; olo = mlo;
    md_model(op, x, y);
    lat = (op <= 3'd2) ? 5 : 10;
    a = x; b = y; mdop = op; start = 1'b1;
    #1;
    chk("md_stall", {63'd0, stall}, 64'd1);
    tick();
    start = 1'b0; mdop = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      chk("md_hold", {hi, lo}, {ohi, olo});
      if (inject && n == 2) begin
        a = ~x; b = y + 1; mdop = 3'd1; start = 1'b1;
      end
      tick();
      start = 1'b0; mdop = 3'd0;
    end
    chk("busy_len", 64'(n), 64'(lat));
    chk("md_hi", {32'd0, hi}, {32'd0, mhi});
    chk("md_lo", {32'd0, lo}, {32'd0, mlo});
  endtask

  task automatic mt_run(input logic [2:0] op,
                        input logic [31:0] x,
                        input logic c);
    a = x; mdop = op; start = 1'b1; cancel = c;
    #1;
    chk("mt_stall", {63'd0, stall}, 64'd0);
    tick();
    start = 1'b0; mdop = 3'd0; cancel = 1'b0;
    if (!c && op == 3'd5) mhi = x;
    if (!c && op == 3'd6) mlo = x;
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_hilo", {hi, lo}, {mhi, mlo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    logic [2:0] op;
    int n;

    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst", {31'd0, busy, hi, lo}, 64'd0);

    alu_chk(4'd0, 32'h7FFF_FFFF, 32'd1, 3'b100);
    chk("add_ovf_res", {32'd0, res}, 64'h8000_0000);
    chk("add_ovf_flag", {63'd0, ov}, 64'd1);
    alu_chk(4'd0, 32'h7FFF_FFFF, 32'd1, 3'b010);
    chk("adel_flag", {63'd0, adel}, 64'd1);
    alu_chk(4'd11, 32'd4, 32'hF000_0000, 3'b000);
    chk("sra_const", {32'd0, res}, 64'hFF00_0000);
    alu_chk(4'd5, 32'hFFFF_FFFF, 32'd1, 3'b000);
    chk("slt_const", {32'd0, res}, 64'd1);
    alu_chk(4'd6, 32'hFFFF_FFFF, 32'd1, 3'b000);
    chk("sltu_const", {32'd0, res}, 64'd0);
    alu_chk(4'd1, 32'h8000_0000, 32'd1, 3'b001);
    chk("sub_ades", {63'd0, ades}, 64'd1);
    alu_chk(4'd4, 32'h0, 32'h0000_BEEF, 3'b111);
    alu_chk(4'd13, 32'h1234, 32'h5678, 3'b111);
    alu_chk(4'd2, 32'h7FFF_FFFF, 32'd1, 3'b111);

    for (int i = 0; i < 150; i++) begin
      x = $urandom();
      y = $urandom();
      if (i % 10 == 0) x = 32'h7FFF_FFFF;
      if (i % 10 == 1) y = 32'h8000_0000;
      alu_chk(4'($urandom_range(0, 15)), x, y,
              3'($urandom_range(0, 7)));
    end
    aluop = 4'd0; {fovf, fld, fst} = 3'b000;
    tick();

    md_run(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("mult_hi_c", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo_c", {32'd0, lo}, 64'hFFFF_FFEB);
    md_run(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo_c", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi_c", {32'd0, hi}, 64'hFFFF_FFFF);
    md_run(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    chk("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    chk("divu0_hi", {32'd0, hi}, 64'h1234_5678);
    md_run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    md_run(3'd3, 32'hABCD_0000, 32'd0, 1'b0);

    a = 32'd9; b = 32'd9; mdop = 3'd1;
    start = 1'b1; cancel = 1'b1;
    #1;
    chk("cancel_stall", {63'd0, stall}, 64'd0);
    tick();
    start = 1'b0; cancel = 1'b0; mdop = 3'd0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("cancel_hilo", {31'd0, busy, hi, lo},
        {31'd0, 1'b0, mhi, mlo});
    mt_run(3'd5, 32'hDEAD_BEEF, 1'b1);

    mt_run(3'd5, 32'h0000_1234, 1'b0);
    chk("mthi_c", {32'd0, hi}, 64'h1234);
    mt_run(3'd6, 32'h0000_5678, 1'b0);

    md_run(3'd2, 32'h0001_0003, 32'h0002_0005, 1'b1);
    tick();
    chk("inject_idle", {31'd0, busy, hi, lo},
        {31'd0, 1'b0, mhi, mlo});

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      x = $urandom();
      y = (i % 7 == 3) ? 32'd0 : $urandom();
      if (i % 5 == 0) y = y >> 20;
      if (op >= 3'd5) mt_run(op, x, 1'b0);
      else md_run(op, x, y, 1'b0);
    end

    mt_run(3'd5, 32'hAAAA_AAAA, 1'b0);
    mt_run(3'd6, 32'h5555_5555, 1'b0);
    a = 32'hFFFF_FFFD; b = 32'd7; mdop = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0; mdop = 3'd0;
    tick();
    chk("rst_pre_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    mhi = '0; mlo = '0;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_stays", {31'd0, busy, hi, lo}, 64'd0);

    h_aluop = 4'd4; h_a = 16'h0; h_b = 16'h00AB;
    #1;
    chk("w16_lui", {48'd0, h_res}, 64'hAB00);
    h_aluop = 4'd0; h_a = 16'h7FFF; h_b = 16'h0001;
    #1;
    chk("w16_ovf", {47'd0, h_ov, h_res}, {47'd0, 1'b1, 16'h8000});
    tick();
    h_a = 16'hFFFF; h_b = 16'hFFFF; h_mdop = 3'd2;
    h_start = 1'b1;
    tick();
    h_start = 1'b0; h_mdop = 3'd0;
    n = 0;
    while (h_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("w16_len", 64'(n), 64'd5);
    chk("w16_hi", {48'd0, h_hi}, 64'hFFFE);
    chk("w16_lo", {48'd0, h_lo}, 64'h0001);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
